// File: rtl/ddr_test_pkg.sv
// Shared pattern-mode encodings, FSM states and LFSR definition for the DDR pattern checker.
package ddr_test_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR    = 2'd0,
    MODE_WALK1   = 2'd1,
    MODE_ADDR    = 2'd2,
    MODE_CHECKER = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  // x^32 + x^22 + x^2 + x + 1, feedback taps below the x^32 term
  localparam logic [31:0] LFSR_POLY         = 32'h0040_0007;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/ddr_pattern_gen.sv
// Expected-word generator: LFSR state plus combinational pattern for the current beat index.
module ddr_pattern_gen
  import ddr_test_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  pat_mode_e             mode,
  input  logic [31:0]           seed,
  input  logic [15:0]           beat,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] expected
);

  logic [31:0] lfsr_q, lfsr_d;
  int unsigned walk_pos;

  // An all-zero seed would lock the LFSR, so it is replaced by the default seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)         lfsr_d = (seed == '0) ? LFSR_DEFAULT_SEED : seed;
    else if (advance) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_DEFAULT_SEED;
    else        lfsr_q <= lfsr_d;
  end

  always_comb begin
    expected = '0;
    walk_pos = 32'(beat) % DATA_WIDTH;
    unique case (mode)
      MODE_LFSR:
        for (int unsigned k = 0; k < DATA_WIDTH / 32; k++)
          expected[k*32 +: 32] = lfsr_q ^ {4{k[7:0]}};
      MODE_WALK1:
        for (int unsigned i = 0; i < DATA_WIDTH; i++)
          expected[i] = (i == walk_pos);
      MODE_ADDR:
        for (int unsigned k = 0; k < DATA_WIDTH / 16; k++)
          expected[k*16 +: 16] = beat;
      MODE_CHECKER:
        expected = {(DATA_WIDTH/8){beat[0] ? 8'hAA : 8'h55}};
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/ddr_pattern_checker.sv
// DDR read-data pattern checker: compares user-port read beats against a generated pattern.
module ddr_pattern_checker
  import ddr_test_pkg::*;
#(
  parameter  int MEM_DQ_WIDTH = 32,
  parameter  int BURST_LEN    = 8,
  localparam int DATA_WIDTH   = MEM_DQ_WIDTH * BURST_LEN,
  localparam int LANES        = MEM_DQ_WIDTH / 8
) (
  input  logic                  core_clk,
  input  logic                  ddr_rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [31:0]           seed,
  input  logic [15:0]           test_len,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_flag,
  output logic [15:0]           err_cnt,
  output logic [LANES-1:0]      lane_err,
  output logic [15:0]           first_err_beat
);

  chk_state_e       state_q, state_d;
  pat_mode_e        mode_q, mode_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      beat_q, beat_d;
  logic             err_flag_q, err_flag_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [LANES-1:0] lane_err_q, lane_err_d;
  logic [15:0]      first_q, first_d;

  logic [DATA_WIDTH-1:0] expected, diff;
  logic [LANES-1:0]      lane_mis;
  logic                  start_ok, beat_acc;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign beat_acc = (state_q == ST_RUN) && rd_valid && !abort;

  ddr_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_gen (
    .clk      (core_clk),
    .rst_n    (ddr_rstn),
    .load     (start_ok),
    .mode     (mode_q),
    .seed     (seed),
    .beat     (beat_q),
    .advance  (beat_acc),
    .expected (expected)
  );

  // Byte lane j collects bit errors from the same byte position of every DQ beat in the burst.
  always_comb begin
    diff     = rd_data ^ expected;
    lane_mis = '0;
    for (int unsigned b = 0; b < BURST_LEN; b++)
      for (int unsigned j = 0; j < LANES; j++)
        lane_mis[j] = lane_mis[j] | (|diff[b*MEM_DQ_WIDTH + j*8 +: 8]);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    beat_d     = beat_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    lane_err_d = lane_err_q;
    first_d    = first_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = pat_mode_e'(mode);
          len_d      = test_len;
          beat_d     = '0;
          err_flag_d = 1'b0;
          err_cnt_d  = '0;
          lane_err_d = '0;
          first_d    = '1;
          state_d    = (test_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rd_valid) begin
          beat_d = beat_q + 16'd1;
          if (|lane_mis) begin
            err_flag_d = 1'b1;
            err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 16'd1;
            lane_err_d = lane_err_q | lane_mis;
            if (!err_flag_q) first_d = beat_q;
          end
          if (beat_q == len_q - 16'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_LFSR;
      len_q      <= '0;
      beat_q     <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      lane_err_q <= '0;
      first_q    <= '1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      lane_err_q <= lane_err_d;
      first_q    <= first_d;
    end
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign err_flag       = err_flag_q;
  assign err_cnt        = err_cnt_q;
  assign lane_err       = lane_err_q;
  assign first_err_beat = first_q;

endmodule

// File: tb/tb_ddr_pattern_checker.sv
// Directed, table-driven bench for ddr_pattern_checker at default parameters (256-bit word, 4 lanes).
module tb_ddr_pattern_checker;

  localparam int DW = 256;

  logic          core_clk = 1'b0;
  logic          ddr_rstn;
  logic          start, abort, rd_valid;
  logic [1:0]    mode;
  logic [31:0]   seed;
  logic [15:0]   test_len;
  logic [DW-1:0] rd_data;
  logic          busy, done, err_flag;
  logic [15:0]   err_cnt, first_err_beat;
  logic [3:0]    lane_err;

  int n_checks = 0;
  int n_fail   = 0;

  ddr_pattern_checker #(.MEM_DQ_WIDTH(32), .BURST_LEN(8)) dut (
    .core_clk       (core_clk),
    .ddr_rstn       (ddr_rstn),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .seed           (seed),
    .test_len       (test_len),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .busy           (busy),
    .done           (done),
    .err_flag       (err_flag),
    .err_cnt        (err_cnt),
    .lane_err       (lane_err),
    .first_err_beat (first_err_beat)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] seed;
    int          len;
    bit          gap;
    int          cb_a;
    int          cb_b;
    int          cbit;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_lane;
    logic [15:0] exp_first;
  } tv_t;

  tv_t tv[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) begin
      n[0]  = ~n[0];
      n[1]  = ~n[1];
      n[2]  = ~n[2];
      n[22] = ~n[22];
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] model_word(input int m, input logic [31:0] lf, input int beat);
    logic [DW-1:0] w;
    logic [7:0]    kb;
    w = '0;
    case (m)
      0: for (int k = 0; k < 8; k++) begin
           kb = 8'(k);
           w[k*32 +: 32] = lf ^ {kb, kb, kb, kb};
         end
      1: w[beat % DW] = 1'b1;
      2: for (int k = 0; k < 16; k++) w[k*16 +: 16] = 16'(beat);
      default: for (int k = 0; k < 32; k++) w[k*8 +: 8] = (beat % 2 == 1) ? 8'hAA : 8'h55;
    endcase
    return w;
  endfunction

  task automatic chk_results(input string tag, input logic [15:0] cnt, input logic [3:0] lane,
                             input logic [15:0] first);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(cnt));
    chk({tag, "_err_flag"}, 32'(err_flag), 32'(cnt != 0));
    chk({tag, "_lane_err"}, 32'(lane_err), 32'(lane));
    chk({tag, "_first_err"}, 32'(first_err_beat), 32'(first));
  endtask

  task automatic run_vec(input int idx, input tv_t t);
    logic [31:0]   lf;
    logic [DW-1:0] d;
    int            beat, cyc;
    bit            early;
    string         tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge core_clk);
    mode = t.mode; seed = t.seed; test_len = 16'(t.len); start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    lf = (t.seed == 0) ? 32'h1 : t.seed;
    beat = 0; cyc = 0; early = 1'b0;
    while (beat < t.len) begin
      if (t.gap && cyc[0]) begin
        rd_valid = 1'b0;
        rd_data  = {8{$urandom}};
      end else begin
        d = model_word(int'(t.mode), lf, beat);
        if (beat == t.cb_a || beat == t.cb_b) d[t.cbit] = ~d[t.cbit];
        rd_valid = 1'b1;
        rd_data  = d;
      end
      @(negedge core_clk);
      if (rd_valid) begin
        if (beat == t.cb_a) begin
          chk({tag, "_flag_latency"}, 32'(err_flag), 32'd1);
          chk({tag, "_first_latency"}, 32'(first_err_beat), 32'(t.cb_a));
        end
        lf = tb_lfsr_step(lf);
        beat++;
        if (beat < t.len && done) early = 1'b1;
      end else if (done) begin
        early = 1'b1;
      end
      cyc++;
    end
    rd_valid = 1'b0;
    chk({tag, "_no_early_done"}, 32'(early), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk_results(tag, t.exp_cnt, t.exp_lane, t.exp_first);
    @(negedge core_clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int b;
    tv[0] = '{2'd2, 32'h0,        4,   1'b0, -1,  -1, 0,   16'd0, 4'b0000, 16'hFFFF};
    tv[1] = '{2'd0, 32'h0,        16,  1'b0, 5,   -1, 18,  16'd1, 4'b0100, 16'd5};
    tv[2] = '{2'd3, 32'h0,        8,   1'b1, -1,  -1, 0,   16'd0, 4'b0000, 16'hFFFF};
    tv[3] = '{2'd1, 32'h0,        20,  1'b0, 3,   -1, 255, 16'd1, 4'b1000, 16'd3};
    tv[4] = '{2'd0, 32'hDEADBEEF, 40,  1'b0, 0,   -1, 40,  16'd1, 4'b0010, 16'd0};
    tv[5] = '{2'd1, 32'h0,        300, 1'b0, 260, -1, 4,   16'd1, 4'b0001, 16'd260};
    tv[6] = '{2'd3, 32'h0,        10,  1'b1, 2,   7,  9,   16'd2, 4'b0010, 16'd2};

    ddr_rstn = 1'b0; start = 1'b0; abort = 1'b0; rd_valid = 1'b0;
    mode = 2'd0; seed = '0; test_len = '0; rd_data = '0;
    repeat (3) @(negedge core_clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk_results("reset", 16'd0, 4'b0000, 16'hFFFF);
    ddr_rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, tv[i]);

    // Zero-length test: done directly, busy never asserted, previous results cleared.
    @(negedge core_clk);
    mode = 2'd2; test_len = 16'd0; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    chk("zlen_done", 32'(done), 32'd1);
    chk("zlen_busy", 32'(busy), 32'd0);
    chk_results("zlen", 16'd0, 4'b0000, 16'hFFFF);
    @(negedge core_clk);
    chk("zlen_done_drop", 32'(done), 32'd0);
    chk("zlen_busy_idle", 32'(busy), 32'd0);

    // Second start during RUN must not restart or re-latch the test.
    mode = 2'd2; test_len = 16'd4; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_valid = 1'b1; rd_data = model_word(2, 32'h0, k);
      if (k == 2) begin start = 1'b1; mode = 2'd3; test_len = 16'd2; end
      @(negedge core_clk);
      start = 1'b0;
    end
    rd_valid = 1'b0;
    chk("restart_ignored_done", 32'(done), 32'd1);
    chk_results("restart_ignored", 16'd0, 4'b0000, 16'hFFFF);
    @(negedge core_clk);

    // Abort at beat 50 of 100 walking-one beats; results retained, no done.
    mode = 2'd1; test_len = 16'd100; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      rd_valid = 1'b1; rd_data = model_word(1, 32'h0, k);
      if (k == 10) rd_data[200] = ~rd_data[200];
      if (k == 50) abort = 1'b1;
      @(negedge core_clk);
    end
    abort = 1'b0; rd_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk_results("abort", 16'd1, 4'b0010, 16'd10);
    // Corrupt beats while idle must be ignored.
    for (int k = 0; k < 3; k++) begin
      rd_valid = 1'b1; rd_data = {8{32'hFFFF_FFFF}};
      @(negedge core_clk);
      chk("idle_no_done", 32'(done), 32'd0);
    end
    rd_valid = 1'b0;
    chk_results("idle_ignored", 16'd1, 4'b0010, 16'd10);

    // Abort wins over a simultaneous final beat.
    mode = 2'd2; test_len = 16'd3; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd_valid = 1'b1; rd_data = model_word(2, 32'h0, k);
      if (k == 2) abort = 1'b1;
      @(negedge core_clk);
    end
    abort = 1'b0; rd_valid = 1'b0;
    chk("abort_final_done", 32'(done), 32'd0);
    chk("abort_final_busy", 32'(busy), 32'd0);
    @(negedge core_clk);
    chk("abort_final_done_later", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a running test with an error already recorded.
    mode = 2'd0; seed = 32'h1234_5678; test_len = 16'd100; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    rd_valid = 1'b1; rd_data = '0;
    repeat (5) @(negedge core_clk);
    chk("prereset_err_flag", 32'(err_flag), 32'd1);
    #2 ddr_rstn = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk_results("midreset", 16'd0, 4'b0000, 16'hFFFF);
    rd_valid = 1'b0;
    @(negedge core_clk);
    ddr_rstn = 1'b1;
    run_vec(10, tv[1]);

    // Full-length address test with every beat corrupted.
    @(negedge core_clk);
    mode = 2'd2; test_len = 16'hFFFF; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    b = 0;
    while (b < 65535) begin
      rd_valid = 1'b1;
      rd_data  = model_word(2, 32'h0, b) ^ 256'h1;
      @(negedge core_clk);
      b++;
    end
    rd_valid = 1'b0;
    chk("sat_done", 32'(done), 32'd1);
    chk_results("sat", 16'hFFFF, 4'b0001, 16'd0);
    @(negedge core_clk);
    chk("sat_idle", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
